// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage -- instruction decode stage of the five-stage MIPS pipeline.
//
// Decodes the supported MIPS subset, resolves branch and jump targets in ID
// (one architectural delay slot, which this stage never squashes), detects
// operand hazards by comparing each operand's Tuse against the producer's
// Tnew, forwards operands from EX/MEM, and holds the ID/EX pipeline register.
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   id_pc, id_instr          pc and instruction currently in ID (0 = nop)
//   rs_addr, rt_addr         GRF read addresses (instr[25:21], instr[20:16])
//   rs_rdata, rt_rdata       GRF read data (combinational, write-through)
//   m_wa, m_wd, m_tnew       MEM-stage destination, result, cycles to ready
//   stall                    hold fetch and ID, inject a bubble into EX
//   j, npc                   redirect kind (0 seq,1 br,2 j/jal,3 jr) + target
//   ex_pc .. ex_tnew         ID/EX register contents feeding EX
//
// Handshake: there is no valid/ready pair. stall is the only flow control:
// while stall=1 the producer (fetch) must present the same id_pc/id_instr
// on the next cycle, and EX receives a bubble (all-zero ID/EX contents).
// ---------------------------------------------------------------------------
module id_stage #(
  parameter int RA_REG      = 31,
  parameter int LINK_OFFSET = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_instr,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  input  logic [31:0] rs_rdata,
  input  logic [31:0] rt_rdata,
  input  logic [4:0]  m_wa,
  input  logic [31:0] m_wd,
  input  logic [1:0]  m_tnew,
  output logic        stall,
  output logic [2:0]  j,
  output logic [31:0] npc,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_rs_val,
  output logic [31:0] ex_rt_val,
  output logic [31:0] ex_imm32,
  output logic [3:0]  ex_op,
  output logic [4:0]  ex_wa,
  output logic [1:0]  ex_tnew
);

  // Internal operation codes, also the encoding of ex_op.
  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADDU = 4'd1;
  localparam logic [3:0] OP_SUBU = 4'd2;
  localparam logic [3:0] OP_ORI  = 4'd3;
  localparam logic [3:0] OP_LUI  = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_SW   = 4'd6;
  localparam logic [3:0] OP_BEQ  = 4'd7;
  localparam logic [3:0] OP_BNE  = 4'd8;
  localparam logic [3:0] OP_J    = 4'd9;
  localparam logic [3:0] OP_JAL  = 4'd10;
  localparam logic [3:0] OP_JR   = 4'd11;

  // MIPS primary opcodes and R-type function codes.
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_LUI   = 6'h0F;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;
  localparam logic [5:0] FN_JR     = 6'h08;
  localparam logic [5:0] FN_ADDU   = 6'h21;
  localparam logic [5:0] FN_SUBU   = 6'h23;

  localparam logic [4:0]  RA_ADDR  = 5'(RA_REG);
  localparam logic [31:0] LINK_OFF = 32'(LINK_OFFSET);

  // Instruction fields.
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rd_addr;
  logic [15:0] imm16;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;

  assign opcode   = id_instr[31:26];
  assign funct    = id_instr[5:0];
  assign rs_addr  = id_instr[25:21];
  assign rt_addr  = id_instr[20:16];
  assign rd_addr  = id_instr[15:11];
  assign imm16    = id_instr[15:0];
  assign imm_sext = {{16{imm16[15]}}, imm16};
  assign imm_zext = {16'h0000, imm16};

  // Decoded control.
  logic [3:0]  dec_op;
  logic [4:0]  dec_wa;
  logic [1:0]  dec_tnew;
  logic [31:0] dec_imm32;
  logic        rs_use;
  logic        rt_use;
  logic [1:0]  rs_tuse;
  logic [1:0]  rt_tuse;

  always_comb begin
    dec_op    = OP_NOP;
    dec_wa    = 5'd0;
    dec_tnew  = 2'd0;
    dec_imm32 = 32'h0;
    rs_use    = 1'b0;
    rt_use    = 1'b0;
    rs_tuse   = 2'd0;
    rt_tuse   = 2'd0;
    case (opcode)
      OPC_RTYPE: begin
        case (funct)
          FN_ADDU, FN_SUBU: begin
            dec_op    = (funct == FN_ADDU) ? OP_ADDU : OP_SUBU;
            dec_wa    = rd_addr;
            dec_tnew  = 2'd1;
            // addu keeps the sign-extended low half; subu carries no immediate.
            dec_imm32 = (funct == FN_ADDU) ? imm_sext : 32'h0;
            rs_use    = 1'b1;
            rt_use    = 1'b1;
            rs_tuse   = 2'd1;
            rt_tuse   = 2'd1;
          end
          FN_JR: begin
            dec_op  = OP_JR;
            rs_use  = 1'b1;
            rs_tuse = 2'd0;
          end
          default: ;
        endcase
      end
      OPC_ORI: begin
        dec_op    = OP_ORI;
        dec_wa    = rt_addr;
        dec_tnew  = 2'd1;
        dec_imm32 = imm_zext;
        rs_use    = 1'b1;
        rs_tuse   = 2'd1;
      end
      OPC_LUI: begin
        dec_op    = OP_LUI;
        dec_wa    = rt_addr;
        dec_tnew  = 2'd1;
        dec_imm32 = {imm16, 16'h0000};
      end
      OPC_LW: begin
        dec_op    = OP_LW;
        dec_wa    = rt_addr;
        dec_tnew  = 2'd2;
        dec_imm32 = imm_sext;
        rs_use    = 1'b1;
        rs_tuse   = 2'd1;
      end
      OPC_SW: begin
        dec_op    = OP_SW;
        dec_imm32 = imm_sext;
        rs_use    = 1'b1;
        rs_tuse   = 2'd1;
        // Store data is only needed in MEM, two cycles after ID.
        rt_use    = 1'b1;
        rt_tuse   = 2'd2;
      end
      OPC_BEQ, OPC_BNE: begin
        dec_op    = (opcode == OPC_BEQ) ? OP_BEQ : OP_BNE;
        dec_imm32 = imm_sext;
        rs_use    = 1'b1;
        rt_use    = 1'b1;
      end
      OPC_J: begin
        dec_op = OP_J;
      end
      OPC_JAL: begin
        dec_op   = OP_JAL;
        dec_wa   = RA_ADDR;
        dec_tnew = 2'd0;
      end
      default: ;
    endcase
  end

  // Operand forwarding. A producer in EX can only have Tnew=0 if it is a
  // link write (jal), whose value is known from its pc alone.
  logic [31:0] rs_fwd;
  logic [31:0] rt_fwd;

  always_comb begin
    rs_fwd = rs_rdata;
    if (rs_addr != 5'd0 && rs_addr == ex_wa && ex_tnew == 2'd0) begin
      rs_fwd = ex_pc + LINK_OFF;
    end else if (rs_addr != 5'd0 && rs_addr == m_wa && m_tnew == 2'd0) begin
      rs_fwd = m_wd;
    end
  end

  always_comb begin
    rt_fwd = rt_rdata;
    if (rt_addr != 5'd0 && rt_addr == ex_wa && ex_tnew == 2'd0) begin
      rt_fwd = ex_pc + LINK_OFF;
    end else if (rt_addr != 5'd0 && rt_addr == m_wa && m_tnew == 2'd0) begin
      rt_fwd = m_wd;
    end
  end

  // Hazard detection: stall while a needed producer is further from ready
  // than this instruction can wait.
  logic rs_haz;
  logic rt_haz;

  always_comb begin
    rs_haz = rs_use && (rs_addr != 5'd0) &&
             ((rs_addr == ex_wa && ex_tnew > rs_tuse) ||
              (rs_addr == m_wa  && m_tnew  > rs_tuse));
    rt_haz = rt_use && (rt_addr != 5'd0) &&
             ((rt_addr == ex_wa && ex_tnew > rt_tuse) ||
              (rt_addr == m_wa  && m_tnew  > rt_tuse));
  end

  assign stall = rs_haz | rt_haz;

  // Redirect. Suppressed while stalled because the operands are stale.
  logic [31:0] br_target;
  logic [31:0] jmp_target;

  assign br_target  = id_pc + 32'd4 + {imm_sext[29:0], 2'b00};
  assign jmp_target = {id_pc[31:28], id_instr[25:0], 2'b00};

  always_comb begin
    j   = 3'd0;
    npc = id_pc + 32'd4;
    if (!stall) begin
      case (dec_op)
        OP_BEQ: begin
          if (rs_fwd == rt_fwd) begin
            j   = 3'd1;
            npc = br_target;
          end
        end
        OP_BNE: begin
          if (rs_fwd != rt_fwd) begin
            j   = 3'd1;
            npc = br_target;
          end
        end
        OP_J, OP_JAL: begin
          j   = 3'd2;
          npc = jmp_target;
        end
        OP_JR: begin
          j   = 3'd3;
          npc = rs_fwd;
        end
        default: ;
      endcase
    end
  end

  // ID/EX register. A bubble is the all-zero encoding (nop, no dest, Tnew 0).
  always_ff @(posedge clk) begin
    if (rst || stall) begin
      ex_pc     <= 32'h0;
      ex_rs_val <= 32'h0;
      ex_rt_val <= 32'h0;
      ex_imm32  <= 32'h0;
      ex_op     <= OP_NOP;
      ex_wa     <= 5'd0;
      ex_tnew   <= 2'd0;
    end else begin
      ex_pc     <= id_pc;
      ex_rs_val <= rs_fwd;
      ex_rt_val <= rt_fwd;
      ex_imm32  <= dec_imm32;
      ex_op     <= dec_op;
      ex_wa     <= dec_wa;
      ex_tnew   <= dec_tnew;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// ---------------------------------------------------------------------------
// tb_id_stage -- self-checking bench for id_stage.
// Combinational outputs (stall, j, npc, read addresses) are checked inline
// in each scenario task; the ID/EX register contents expected after each
// clock edge are pushed to exp_q and checked by the scoreboard process.
// ---------------------------------------------------------------------------
module tb_id_stage;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADDU = 4'd1;
  localparam logic [3:0] OP_SUBU = 4'd2;
  localparam logic [3:0] OP_ORI  = 4'd3;
  localparam logic [3:0] OP_LUI  = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_SW   = 4'd6;
  localparam logic [3:0] OP_BEQ  = 4'd7;
  localparam logic [3:0] OP_BNE  = 4'd8;
  localparam logic [3:0] OP_J    = 4'd9;
  localparam logic [3:0] OP_JAL  = 4'd10;
  localparam logic [3:0] OP_JR   = 4'd11;

  localparam int W = 139;

  // Clock / reset / DUT signals
  logic        clk;
  logic        rst;
  logic [31:0] id_pc, id_instr;
  logic [4:0]  rs_addr, rt_addr;
  logic [31:0] rs_rdata, rt_rdata;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  logic [1:0]  m_tnew;
  logic        stall;
  logic [2:0]  j;
  logic [31:0] npc;
  logic [31:0] ex_pc, ex_rs_val, ex_rt_val, ex_imm32;
  logic [3:0]  ex_op;
  logic [4:0]  ex_wa;
  logic [1:0]  ex_tnew;

  logic [W-1:0] exp_q[$];
  int vectors;
  int miscompares;

  id_stage dut (
    .clk(clk), .rst(rst), .id_pc(id_pc), .id_instr(id_instr),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_rdata(rs_rdata), .rt_rdata(rt_rdata),
    .m_wa(m_wa), .m_wd(m_wd), .m_tnew(m_tnew), .stall(stall), .j(j), .npc(npc),
    .ex_pc(ex_pc), .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val), .ex_imm32(ex_imm32),
    .ex_op(ex_op), .ex_wa(ex_wa), .ex_tnew(ex_tnew)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Encoders and expectation packing
  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] opc, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  function automatic logic [31:0] sx(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [W-1:0] pk(input logic [3:0] op, input logic [4:0] wa,
                                      input logic [1:0] tn, input logic [31:0] pc,
                                      input logic [31:0] rsv, input logic [31:0] rtv,
                                      input logic [31:0] imm);
    return {op, wa, tn, pc, rsv, rtv, imm};
  endfunction

  // Scoreboard: one expected ID/EX value per clock edge while entries exist.
  task automatic run_scoreboard();
    logic [W-1:0] e;
    logic [W-1:0] a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {ex_op, ex_wa, ex_tnew, ex_pc, ex_rs_val, ex_rt_val, ex_imm32};
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL idex_reg: got op=%0d wa=%0d tnew=%0d pc=%h rs=%h rt=%h imm=%h, expected op=%0d wa=%0d tnew=%0d pc=%h rs=%h rt=%h imm=%h",
                   a[138:135], a[134:130], a[129:128], a[127:96], a[95:64], a[63:32], a[31:0],
                   e[138:135], e[134:130], e[129:128], e[127:96], e[95:64], e[63:32], e[31:0]);
        end
      end
    end
  endtask

  task automatic drive_idle();
    m_wa = 5'd0; m_wd = 32'h0; m_tnew = 2'd0;
    rs_rdata = 32'h0; rt_rdata = 32'h0;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      rst = 1'b1; id_pc = 32'h0; id_instr = 32'h0; drive_idle();
      #1;
      vectors++;
      if (stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b, expected 0", stall); end
      vectors++;
      if (j !== 3'd0) begin miscompares++; $display("FAIL reset_j: got %0d, expected 0", j); end
      exp_q.push_back(pk(OP_NOP, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0));
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_load_use();
    // lw $8,4($9) into EX
    id_pc = 32'h100; id_instr = itype(6'h23, 5'd9, 5'd8, 16'd4);
    rs_rdata = 32'h1000; rt_rdata = 32'h0;
    #1;
    vectors++;
    if (stall !== 1'b0) begin miscompares++; $display("FAIL lw_stall: got %b, expected 0", stall); end
    exp_q.push_back(pk(OP_LW, 5'd8, 2'd2, 32'h100, 32'h1000, 32'h0, 32'h4));
    // beq $8,$0 behind lw in EX
    @(negedge clk);
    id_pc = 32'h104; id_instr = itype(6'h04, 5'd8, 5'd0, 16'd3);
    rs_rdata = 32'h0; rt_rdata = 32'h0;
    #1;
    vectors++;
    if (stall !== 1'b1) begin miscompares++; $display("FAIL lu_ex_stall: got %b, expected 1", stall); end
    vectors++;
    if (j !== 3'd0) begin miscompares++; $display("FAIL lu_ex_j: got %0d, expected 0", j); end
    exp_q.push_back(pk(OP_NOP, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0));
    // lw now in MEM, one cycle short
    @(negedge clk);
    m_wa = 5'd8; m_tnew = 2'd1; m_wd = 32'h0;
    #1;
    vectors++;
    if (stall !== 1'b1) begin miscompares++; $display("FAIL lu_m_stall: got %b, expected 1", stall); end
    exp_q.push_back(pk(OP_NOP, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0));
    // result ready in MEM
    @(negedge clk);
    m_tnew = 2'd0; m_wd = 32'h5;
    #1;
    vectors++;
    if (stall !== 1'b0) begin miscompares++; $display("FAIL lu_ready_stall: got %b, expected 0", stall); end
    vectors++;
    if (j !== 3'd0) begin miscompares++; $display("FAIL lu_ready_j: got %0d, expected 0", j); end
    exp_q.push_back(pk(OP_BEQ, 5'd0, 2'd0, 32'h104, 32'h5, 32'h0, 32'h3));
  endtask

  task automatic test_forward_m();
    @(negedge clk);
    id_pc = 32'h200; id_instr = rtype(5'd1, 5'd2, 5'd3, 6'h21);
    m_wa = 5'd1; m_tnew = 2'd0; m_wd = 32'h11; rs_rdata = 32'h99; rt_rdata = 32'h22;
    #1;
    vectors++;
    if (rs_addr !== 5'd1 || rt_addr !== 5'd2) begin
      miscompares++; $display("FAIL rd_addr: got %0d/%0d, expected 1/2", rs_addr, rt_addr);
    end
    vectors++;
    if (stall !== 1'b0) begin miscompares++; $display("FAIL fwd_stall: got %b, expected 0", stall); end
    exp_q.push_back(pk(OP_ADDU, 5'd3, 2'd1, 32'h200, 32'h11, 32'h22, 32'h1821));
  endtask

  task automatic test_branch();
    @(negedge clk);
    drive_idle();
    id_pc = 32'h3008; id_instr = itype(6'h04, 5'd1, 5'd2, 16'hFFFE);
    rs_rdata = 32'h55; rt_rdata = 32'h55;
    #1;
    vectors++;
    if (j !== 3'd1 || npc !== 32'h3004) begin
      miscompares++; $display("FAIL beq_taken: got j=%0d npc=%h, expected j=1 npc=00003004", j, npc);
    end
    exp_q.push_back(pk(OP_BEQ, 5'd0, 2'd0, 32'h3008, 32'h55, 32'h55, 32'hFFFFFFFE));
    @(negedge clk);
    id_instr = itype(6'h05, 5'd1, 5'd2, 16'hFFFE);
    #1;
    vectors++;
    if (j !== 3'd0) begin miscompares++; $display("FAIL bne_not_taken: got %0d, expected 0", j); end
    exp_q.push_back(pk(OP_BNE, 5'd0, 2'd0, 32'h3008, 32'h55, 32'h55, 32'hFFFFFFFE));
    @(negedge clk);
    id_pc = 32'h3010; id_instr = itype(6'h05, 5'd1, 5'd2, 16'h0010); rt_rdata = 32'h56;
    #1;
    vectors++;
    if (j !== 3'd1 || npc !== 32'h3054) begin
      miscompares++; $display("FAIL bne_taken: got j=%0d npc=%h, expected j=1 npc=00003054", j, npc);
    end
    exp_q.push_back(pk(OP_BNE, 5'd0, 2'd0, 32'h3010, 32'h55, 32'h56, 32'h10));
  endtask

  task automatic test_jal_jr();
    @(negedge clk);
    drive_idle();
    id_pc = 32'h3000; id_instr = {6'h03, 26'h0000C01};
    rs_rdata = 32'h7; rt_rdata = 32'h9;
    #1;
    vectors++;
    if (j !== 3'd2 || npc !== 32'h3004) begin
      miscompares++; $display("FAIL jal_redirect: got j=%0d npc=%h, expected j=2 npc=00003004", j, npc);
    end
    exp_q.push_back(pk(OP_JAL, 5'd31, 2'd0, 32'h3000, 32'h7, 32'h9, 32'h0));
    // jr $31: EX link value must beat a ready MEM write to the same register
    @(negedge clk);
    id_pc = 32'h3004; id_instr = rtype(5'd31, 5'd0, 5'd0, 6'h08);
    rs_rdata = 32'hDEAD; rt_rdata = 32'h0;
    m_wa = 5'd31; m_tnew = 2'd0; m_wd = 32'h1234;
    #1;
    vectors++;
    if (stall !== 1'b0) begin miscompares++; $display("FAIL jr_stall: got %b, expected 0", stall); end
    vectors++;
    if (j !== 3'd3 || npc !== 32'h3008) begin
      miscompares++; $display("FAIL jr_redirect: got j=%0d npc=%h, expected j=3 npc=00003008", j, npc);
    end
    exp_q.push_back(pk(OP_JR, 5'd0, 2'd0, 32'h3004, 32'h3008, 32'h0, 32'h0));
  endtask

  task automatic test_sw_tuse();
    @(negedge clk);
    drive_idle();
    rs_rdata = 32'hA0; rt_rdata = 32'hB0;
    id_pc = 32'h400; id_instr = itype(6'h23, 5'd1, 5'd5, 16'h0);
    #1;
    exp_q.push_back(pk(OP_LW, 5'd5, 2'd2, 32'h400, 32'hA0, 32'hB0, 32'h0));
    @(negedge clk);
    id_pc = 32'h404; id_instr = itype(6'h2B, 5'd6, 5'd5, 16'h0);
    #1;
    vectors++;
    if (stall !== 1'b0) begin miscompares++; $display("FAIL sw_rt_tuse2: got %b, expected 0", stall); end
    exp_q.push_back(pk(OP_SW, 5'd0, 2'd0, 32'h404, 32'hA0, 32'hB0, 32'h0));
    @(negedge clk);
    id_pc = 32'h408; id_instr = itype(6'h23, 5'd1, 5'd6, 16'h0);
    #1;
    exp_q.push_back(pk(OP_LW, 5'd6, 2'd2, 32'h408, 32'hA0, 32'hB0, 32'h0));
    @(negedge clk);
    id_pc = 32'h40C; id_instr = itype(6'h2B, 5'd6, 5'd5, 16'h0);
    #1;
    vectors++;
    if (stall !== 1'b1) begin miscompares++; $display("FAIL sw_rs_tuse1: got %b, expected 1", stall); end
    exp_q.push_back(pk(OP_NOP, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0));
    @(negedge clk);
    #1;
    vectors++;
    if (stall !== 1'b0) begin miscompares++; $display("FAIL sw_after_bubble: got %b, expected 0", stall); end
    exp_q.push_back(pk(OP_SW, 5'd0, 2'd0, 32'h40C, 32'hA0, 32'hB0, 32'h0));
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    drive_idle();
    rs_rdata = 32'h77; rt_rdata = 32'h77;
    id_pc = 32'h500; id_instr = itype(6'h23, 5'd1, 5'd7, 16'h0);
    #1;
    exp_q.push_back(pk(OP_LW, 5'd7, 2'd2, 32'h500, 32'h77, 32'h77, 32'h0));
    @(negedge clk);
    rst = 1'b1;
    id_pc = 32'h504; id_instr = itype(6'h04, 5'd7, 5'd7, 16'h1);
    #1;
    vectors++;
    if (stall !== 1'b1 || j !== 3'd0) begin
      miscompares++; $display("FAIL rst_mid_stall: got stall=%b j=%0d, expected stall=1 j=0", stall, j);
    end
    exp_q.push_back(pk(OP_NOP, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0));
    @(negedge clk);
    #1;
    vectors++;
    if (stall !== 1'b0 || j !== 3'd1 || npc !== 32'h50C) begin
      miscompares++; $display("FAIL rst_mid_redirect: got stall=%b j=%0d npc=%h, expected stall=0 j=1 npc=0000050c", stall, j, npc);
    end
    exp_q.push_back(pk(OP_NOP, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    exp_q.push_back(pk(OP_BEQ, 5'd0, 2'd0, 32'h504, 32'h77, 32'h77, 32'h1));
  endtask

  // Random hazard-free stream of ALU ops and stores, one per cycle.
  task automatic test_back_to_back();
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [31:0] rsd, rtd, pc, ins;
    int kind;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      kind = $urandom_range(0, 3);
      rs = 5'($urandom_range(0, 31)); rt = 5'($urandom_range(0, 31));
      rd = 5'($urandom_range(0, 31)); imm = 16'($urandom);
      rsd = $urandom; rtd = $urandom; pc = 32'h600 + 32'(i * 4);
      id_pc = pc; rs_rdata = rsd; rt_rdata = rtd;
      m_wa = 5'd0; m_tnew = 2'd0; m_wd = 32'h0;
      case (kind)
        0: begin
          ins = itype(6'h0D, rs, rt, imm);
          exp_q.push_back(pk(OP_ORI, rt, 2'd1, pc, rsd, rtd, {16'h0, imm}));
        end
        1: begin
          ins = itype(6'h0F, rs, rt, imm);
          exp_q.push_back(pk(OP_LUI, rt, 2'd1, pc, rsd, rtd, {imm, 16'h0}));
        end
        2: begin
          ins = rtype(rs, rt, rd, 6'h21);
          exp_q.push_back(pk(OP_ADDU, rd, 2'd1, pc, rsd, rtd, sx(ins[15:0])));
        end
        default: begin
          ins = itype(6'h2B, rs, rt, imm);
          exp_q.push_back(pk(OP_SW, 5'd0, 2'd0, pc, rsd, rtd, sx(imm)));
        end
      endcase
      id_instr = ins;
      #1;
      vectors++;
      if (stall !== 1'b0 || j !== 3'd0) begin
        miscompares++; $display("FAIL b2b_ctrl[%0d]: got stall=%b j=%0d, expected stall=0 j=0", i, stall, j);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1; id_pc = 32'h0; id_instr = 32'h0;
    drive_idle();
    fork
      run_scoreboard();
    join_none
    test_reset();
    test_load_use();
    test_forward_m();
    test_branch();
    test_jal_jr();
    test_sw_tuse();
    test_mid_reset();
    test_back_to_back();
    @(negedge clk);
    id_instr = 32'h0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL sb_drain: got %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
